// File: rtl/game_pkg.sv
// Shared game definitions: screen bounds, slot record and spawner FSM states.
package game_pkg;

  localparam int unsigned X_MAX = 640;
  localparam int unsigned Y_MAX = 480;
  localparam int unsigned POS_W = 10;
  localparam int unsigned SPD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    SPAWN = 2'd2
  } state_e;

  typedef struct packed {
    logic             alive;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic [SPD_W-1:0] x_speed;
    logic [SPD_W-1:0] y_speed;
  } slot_t;

endpackage

// File: rtl/meteor_spawner_if.sv
// Bundle of the spawner's frame/random inputs, kill requests and slot outputs.
interface meteor_spawner_if #(
  parameter int unsigned OBJ_NUM = 4
);
  import game_pkg::*;

  logic                           frame_clk_rising;
  logic [POS_W-1:0]               new_obj_x;
  logic [SPD_W-1:0]               new_x_speed;
  logic [SPD_W-1:0]               new_y_speed;
  logic [OBJ_NUM-1:0]             kill;
  logic [OBJ_NUM-1:0]             obj_alive;
  logic [OBJ_NUM-1:0][POS_W-1:0]  obj_x;
  logic [OBJ_NUM-1:0][POS_W-1:0]  obj_y;
  logic                           busy;
  logic [7:0]                     spawn_total;

  modport master (
    output frame_clk_rising, new_obj_x, new_x_speed, new_y_speed, kill,
    input  obj_alive, obj_x, obj_y, busy, spawn_total
  );

  modport slave (
    input  frame_clk_rising, new_obj_x, new_x_speed, new_y_speed, kill,
    output obj_alive, obj_x, obj_y, busy, spawn_total
  );

endinterface

// File: rtl/meteor_step.sv
// Next-position and screen-bounds evaluation for one meteor slot (combinational).
module meteor_step
  import game_pkg::*;
#(
  parameter int unsigned X_MAX = game_pkg::X_MAX,
  parameter int unsigned Y_MAX = game_pkg::Y_MAX
) (
  input  slot_t i_slot,
  output slot_t o_slot_c
);

  localparam int unsigned EXT_W = POS_W + 1;

  logic [EXT_W-1:0] w_x_next;
  logic [EXT_W-1:0] w_y_next;
  logic             w_out;

  // A negative x shows up as the extra top bit being set.
  always_comb begin
    w_x_next = {1'b0, i_slot.x}
             + {{(EXT_W - SPD_W){i_slot.x_speed[SPD_W-1]}}, i_slot.x_speed};
    w_y_next = {1'b0, i_slot.y} + EXT_W'(i_slot.y_speed);
    w_out    = w_x_next[EXT_W-1]
            || (32'(w_x_next) >= X_MAX)
            || (32'(w_y_next) >= Y_MAX);

    o_slot_c = i_slot;
    if (i_slot.alive) begin
      if (w_out) begin
        o_slot_c.alive = 1'b0;
      end else begin
        o_slot_c.x = w_x_next[POS_W-1:0];
        o_slot_c.y = w_y_next[POS_W-1:0];
      end
    end
  end

endmodule

// File: rtl/meteor_spawner.sv
// Meteor slot manager: per-frame movement pass over all slots, then at most one spawn
// into the lowest free slot, gated by a frame cooldown; kills clear slots at any time.
module meteor_spawner
  import game_pkg::*;
#(
  parameter int unsigned OBJ_NUM        = 4,
  parameter int unsigned SPAWN_INTERVAL = 30,
  parameter int unsigned X_MAX          = game_pkg::X_MAX,
  parameter int unsigned Y_MAX          = game_pkg::Y_MAX
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_clk_rising,
  input  logic [POS_W-1:0]              new_obj_x,
  input  logic [SPD_W-1:0]              new_x_speed,
  input  logic [SPD_W-1:0]              new_y_speed,
  input  logic [OBJ_NUM-1:0]            kill,
  output logic [OBJ_NUM-1:0]            obj_alive,
  output logic [OBJ_NUM-1:0][POS_W-1:0] obj_x,
  output logic [OBJ_NUM-1:0][POS_W-1:0] obj_y,
  output logic                          busy,
  output logic [7:0]                    spawn_total
);

  localparam int unsigned IDX_W = (OBJ_NUM > 1) ? $clog2(OBJ_NUM) : 1;
  localparam int unsigned CD_W  = $clog2(SPAWN_INTERVAL + 1);
  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(SPAWN_INTERVAL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OBJ_NUM - 1);

  state_e            r_state;
  logic [IDX_W-1:0]  r_idx;
  slot_t             r_slot [OBJ_NUM];
  logic              r_pending;
  logic              r_busy;
  logic [CD_W-1:0]   r_cooldown;
  logic [7:0]        r_spawn_total;

  slot_t             w_cur;
  slot_t             w_next;
  slot_t             w_spawn_slot;
  logic [IDX_W-1:0]  w_spawn_idx;
  logic              w_spawn_hit;

  // One shared step unit, time-multiplexed across slots during MOVE.
  assign w_cur = r_slot[r_idx];

  meteor_step #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_step (
    .i_slot   (w_cur),
    .o_slot_c (w_next)
  );

  // Lowest-index slot that is dead and not being killed this cycle.
  always_comb begin
    w_spawn_hit = 1'b0;
    w_spawn_idx = '0;
    for (int i = int'(OBJ_NUM) - 1; i >= 0; i--) begin
      if (!r_slot[i].alive && !kill[i]) begin
        w_spawn_hit = 1'b1;
        w_spawn_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_spawn_slot         = '0;
    w_spawn_slot.alive   = 1'b1;
    w_spawn_slot.x       = (32'(new_obj_x) >= X_MAX) ? POS_W'(X_MAX - 1) : new_obj_x;
    w_spawn_slot.x_speed = new_x_speed;
    w_spawn_slot.y_speed = (new_y_speed == '0) ? SPD_W'(1) : new_y_speed;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_pending     <= 1'b0;
      r_busy        <= 1'b0;
      r_cooldown    <= CD_LOAD;
      r_spawn_total <= '0;
      for (int i = 0; i < int'(OBJ_NUM); i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (frame_clk_rising || r_pending) begin
            r_state   <= MOVE;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
            r_idx     <= '0;
          end
        end

        MOVE: begin
          if (frame_clk_rising) begin
            r_pending <= 1'b1;
          end
          if (!kill[r_idx]) begin
            r_slot[r_idx] <= w_next;
          end
          if (r_idx == IDX_LAST) begin
            r_state <= SPAWN;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        SPAWN: begin
          if (frame_clk_rising) begin
            r_pending <= 1'b1;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
          // With every slot occupied the cooldown stays at zero so the next frame retries.
          if (r_cooldown == '0) begin
            if (w_spawn_hit) begin
              r_slot[w_spawn_idx] <= w_spawn_slot;
              r_cooldown          <= CD_LOAD;
              r_spawn_total       <= r_spawn_total + 8'd1;
            end
          end else begin
            r_cooldown <= r_cooldown - CD_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Kill wins over any move or spawn write to the same slot.
      for (int i = 0; i < int'(OBJ_NUM); i++) begin
        if (kill[i]) begin
          r_slot[i].alive <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    obj_alive = '0;
    obj_x     = '0;
    obj_y     = '0;
    for (int i = 0; i < int'(OBJ_NUM); i++) begin
      obj_alive[i] = r_slot[i].alive;
      obj_x[i]     = r_slot[i].x;
      obj_y[i]     = r_slot[i].y;
    end
  end

  assign busy        = r_busy;
  assign spawn_total = r_spawn_total;

endmodule
